pmem_responder: RTL and testbench

Line-granularity physical-memory responder for the cache-to-memory (pmem) protocol. It sits on the memory side of the cache arbiter and serves 128-bit line reads and writes with a fixed, parameterised latency from an internal line array. It checks that requesters hold their requests stable and flags violations. It is synthesizable and doubles as the bench memory model for the pipeline.

---
 rtl/pmem_responder_pkg.sv | 15 +
 rtl/pmem_responder_line_array.sv | 38 +++
 rtl/pmem_responder.sv | 131 +++++++++++++
 tb/tb_pmem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types for the LC-3b memory side: cache lines and the pmem responder FSM states.
package lc3b_types;

    localparam int LINE_WIDTH = 128;

    typedef logic [LINE_WIDTH-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lc3b_pmem_state;

endpackage : lc3b_types

// File: rtl/pmem_responder_line_array.sv
// Single-port line store: synchronous write, registered read.
// Contents are not reset; only the read register is.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [INDEX_WIDTH-1:0] idx_i,
    input  lc3b_line               wdata_i,
    output lc3b_line               rdata_o
);

    lc3b_line mem_q [2**INDEX_WIDTH];
    lc3b_line rdata_q;

    // Line write; the caller never asserts we_i and re_i together.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register: holds its value until the next read so the output stays stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : pmem_line_array

// File: rtl/pmem_responder.sv
// Fixed-latency line responder for the pmem protocol with a request-stability checker.
//
// Handshake: pmem_read / pmem_write are levels raised by the requester in IDLE and
// held, together with pmem_address[15:4], until pmem_resp. pmem_resp is a single-cycle
// completion pulse LATENCY+1 cycles after the request is first sampled; the requester
// drops its request in the following (DONE) cycle. Dropping the request or changing
// the line address before pmem_resp aborts the access and sets the sticky
// protocol_error flag. Asserting both requests at once is treated as a write and is
// also flagged.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int LATENCY     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         protocol_error,
    output logic [1:0]   dbg_state_o
);

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    lc3b_pmem_state state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_write_q, op_write_d;
    logic [11:0]      tag_q, tag_d;
    lc3b_line         wdata_q, wdata_d;
    logic             err_q, err_d;

    logic             arr_we;
    logic             arr_re;
    logic             live_op;
    logic             unused_offset;

    // Byte offset within the line has no meaning for line accesses.
    assign unused_offset = ^pmem_address[3:0];

    // State, counter, latched request and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            tag_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            tag_q      <= tag_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic, stability checker and array access strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        tag_d      = tag_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        live_op    = op_write_q ? pmem_write : pmem_read;

        unique case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    op_write_d = pmem_write;
                    tag_d      = pmem_address[15:4];
                    wdata_d    = pmem_wdata;
                    cnt_d      = CNT_LOAD;
                    state_d    = BUSY;
                    if (pmem_read && pmem_write) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!live_op || (pmem_address[15:4] != tag_q)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    // A reset on this edge must not leave a half-finished write behind.
                    arr_we  = op_write_q && !rst;
                    arr_re  = !op_write_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pmem_line_array #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_array (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .idx_i  (tag_q[INDEX_WIDTH-1:0]),
        .wdata_i(wdata_q),
        .rdata_o(pmem_rdata)
    );

    assign pmem_resp      = (state_q == RESP);
    assign protocol_error = err_q;
    assign dbg_state_o    = state_q;

endmodule : pmem_responder

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: directed scenarios plus randomized traffic against a
// line-level memory model.
module tb_pmem_responder;
    import lc3b_types::*;

    localparam int LAT = 4;
    localparam int IW  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [127:0] pmem_wdata = '0;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         protocol_error;
    logic [1:0]   dbg_state;

    int n_compared = 0;
    int n_mismatched = 0;

    // Memory model: line index -> contents, only for lines the bench has written.
    lc3b_line model_mem [int];

    pmem_responder #(.INDEX_WIDTH(IW), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .protocol_error(protocol_error),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int line_of(input logic [15:0] addr);
        return int'(addr[IW+3:4]);
    endfunction

    function automatic lc3b_line rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Full transaction; returns in the IDLE cycle after DONE. Checks resp timing.
    task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                         input lc3b_line wd, output lc3b_line rd_data, input string name);
        int resp_cnt;
        int resp_cyc;
        resp_cnt = 0;
        resp_cyc = -1;
        rd_data = '0;
        pmem_read = rd;
        pmem_write = wr;
        pmem_address = addr;
        pmem_wdata = wd;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) begin
                resp_cnt++;
                resp_cyc = c;
                rd_data = pmem_rdata;
            end
            next_cycle();
        end
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        if (pmem_resp !== 1'b0) resp_cnt++;
        next_cycle();
        n_compared++;
        if (resp_cyc !== LAT + 1 || resp_cnt !== 1) begin
            n_mismatched++;
            $display("FAIL %s resp timing: got cycle %0d count %0d, expected cycle %0d count 1",
                     name, resp_cyc, resp_cnt, LAT + 1);
        end
        if (wr) model_mem[line_of(addr)] = wd;
    endtask

    task automatic check_read(input logic [15:0] addr, input string name);
        lc3b_line got;
        lc3b_line exp;
        exp = model_mem[line_of(addr)];
        do_op(1'b1, 1'b0, addr, rand_line(), got, name);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s rdata: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_err(input logic exp, input string name);
        n_compared++;
        if (protocol_error !== exp) begin
            n_mismatched++;
            $display("FAIL %s protocol_error: got %b expected %b", name, protocol_error, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_compared += 3;
        if (pmem_resp !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset pmem_resp: got %b expected 0", pmem_resp);
        end
        if (pmem_rdata !== '0) begin
            n_mismatched++;
            $display("FAIL reset pmem_rdata: got %h expected 0", pmem_rdata);
        end
        if (dbg_state !== IDLE) begin
            n_mismatched++;
            $display("FAIL reset state: got %0d expected %0d", dbg_state, IDLE);
        end
        check_err(1'b0, "reset");
        next_cycle();
    endtask

    task automatic test_read_latency();
        lc3b_line dummy;
        do_op(1'b0, 1'b1, 16'h0120, 128'h0123456789ABCDEF0123456789ABCDEF, dummy, "preload");
        check_read(16'h0120, "read_0x12");
        check_err(1'b0, "read_0x12");
    endtask

    task automatic test_offset_alias();
        lc3b_line dummy;
        do_op(1'b0, 1'b1, 16'h0340, {32{4'hA}}, dummy, "write_0x340");
        check_read(16'h034C, "read_0x34C");
        // Bits above the index alias onto the same line.
        check_read(16'hF34C, "read_alias");
    endtask

    task automatic test_back_to_back();
        lc3b_line dummy;
        do_op(1'b0, 1'b1, 16'h0210, rand_line(), dummy, "b2b_w0");
        do_op(1'b0, 1'b1, 16'h0220, rand_line(), dummy, "b2b_w1");
        check_read(16'h0210, "b2b_r0");
        check_read(16'h0220, "b2b_r1");
    endtask

    task automatic test_abort_drop();
        int saw;
        saw = 0;
        pmem_read = 1'b1;
        pmem_address = 16'h0120;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) saw++;
            next_cycle();
        end
        pmem_read = 1'b0;
        @(negedge clk);
        if (pmem_resp === 1'b1) saw++;
        next_cycle();
        @(negedge clk);
        n_compared++;
        if (dbg_state !== IDLE) begin
            n_mismatched++;
            $display("FAIL abort_drop state: got %0d expected %0d", dbg_state, IDLE);
        end
        check_err(1'b1, "abort_drop");
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) saw++;
            next_cycle();
        end
        n_compared++;
        if (saw !== 0) begin
            n_mismatched++;
            $display("FAIL abort_drop resp: got %0d pulses expected 0", saw);
        end
        check_read(16'h0120, "after_abort");
        check_err(1'b1, "sticky_err");
        apply_reset();
        check_err(1'b0, "err_cleared");
    endtask

    task automatic test_abort_addr();
        lc3b_line dummy;
        do_op(1'b0, 1'b1, 16'h0600, rand_line(), dummy, "abort_addr_pre");
        pmem_write = 1'b1;
        pmem_address = 16'h0600;
        pmem_wdata = rand_line();
        next_cycle();
        next_cycle();
        pmem_address = 16'h0610;
        next_cycle();
        pmem_write = 1'b0;
        next_cycle();
        check_err(1'b1, "abort_addr");
        check_read(16'h0600, "abort_addr_nocommit");
        apply_reset();
    endtask

    task automatic test_both();
        lc3b_line dummy;
        do_op(1'b1, 1'b1, 16'h0700, {32{4'h5}}, dummy, "both");
        check_err(1'b1, "both");
        check_read(16'h0700, "both_readback");
        apply_reset();
    endtask

    task automatic test_reset_mid(input logic [15:0] addr, input int rst_cycle);
        lc3b_line dummy;
        int saw;
        saw = 0;
        do_op(1'b0, 1'b1, addr, rand_line(), dummy, "rst_mid_pre");
        check_read(addr, "rst_mid_pre_read");
        pmem_write = 1'b1;
        pmem_address = addr;
        pmem_wdata = rand_line();
        for (int c = 0; c < rst_cycle; c++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) saw++;
            next_cycle();
        end
        rst = 1'b1;
        pmem_write = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_compared += 3;
        if (pmem_rdata !== '0) begin
            n_mismatched++;
            $display("FAIL rst_mid rdata: got %h expected 0", pmem_rdata);
        end
        if (dbg_state !== IDLE) begin
            n_mismatched++;
            $display("FAIL rst_mid state: got %0d expected %0d", dbg_state, IDLE);
        end
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) saw++;
            next_cycle();
        end
        if (saw !== 0) begin
            n_mismatched++;
            $display("FAIL rst_mid resp: got %0d pulses expected 0", saw);
        end
        check_err(1'b0, "rst_mid");
        check_read(addr, "rst_mid_old_data");
    endtask

    task automatic test_random();
        lc3b_line dummy;
        logic [15:0] addr;
        for (int i = 0; i < 8; i++) begin
            addr = {4'h0, 8'(8'h40 + i), 4'h0};
            do_op(1'b0, 1'b1, addr, rand_line(), dummy, "rand_fill");
        end
        for (int i = 0; i < 40; i++) begin
            addr = {4'($urandom), 8'(8'h40 + $urandom_range(0, 7)), 4'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                do_op(1'b0, 1'b1, addr, rand_line(), dummy, "rand_write");
            end else begin
                check_read(addr, "rand_read");
            end
        end
        check_err(1'b0, "rand");
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_read_latency();
        test_offset_alias();
        test_back_to_back();
        test_abort_drop();
        test_abort_addr();
        test_both();
        test_reset_mid(16'h0500, 2);
        test_reset_mid(16'h0510, LAT);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_pmem_responder
